ctr_run_scheduler: RTL and testbench
====================================

// Module: ctr_run_scheduler
// PURPOSE
//  Shares one SR-enabled modulo interval counter between NREQ requesters. A requester asks for a run of N laps.
//  Grants are round-robin. The block issues start/stop to the counter and counts wraps (laps).
//  A fixed drain of 2 cycles after stop lets downstream 2-stage stop delay lines settle.
//  Sits between requester agents and the shared counter datapath; one run is active at a time.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  CNT_W  4   counter width
//  WRAP   13  terminal count; counter wraps WRAP->0, so one lap = WRAP+1 enabled cycles
//  LAP_W  4   width of per-requester lap request
// PORTS
//  clk     in   1            rising-edge clock, single clock domain
//  reset   in   1            synchronous, active-high; sampled only on posedge clk
//  req     in   NREQ         level request per requester; hold until done
//  laps    in   NREQ*LAP_W   lap count per requester, slice i = laps[i*LAP_W +: LAP_W]; 0 means 1
//  gnt     out  NREQ         one-hot grant, registered
//  busy    out  1            |gnt
//  start   out  1            one-cycle pulse when a run begins
//  stop    out  1            one-cycle pulse when a run ends (normal or abort)
//  count   out  CNT_W        current counter value
//  cnt_en  out  1            counter enable (SR flop state)
//  done    out  NREQ         one-cycle pulse to the requester whose run finished
// BEHAVIOUR
//  Reset values: gnt=0, busy=0, start=0, stop=0, count=0, cnt_en=0, done=0.
//  Reset also sets the state to IDLE, rr_ptr=0 and lap_cnt=0. Reset mid-run drops the grant with no done.
//  FSM: IDLE -> RUN -> DRAIN1 -> DRAIN2 -> IDLE.
//  IDLE, any req set:
//   - pick the first set req scanning from rr_ptr upward, wrapping modulo NREQ;
//   - latch idx and laps (0 becomes 1);
//   - next cycle gnt[idx]=1 and start=1; state RUN.
//  RUN, cycle with start=1: at that edge cnt_en<=1, count<=0, lap_cnt<=0.
//  RUN, cnt_en=1: count increments each edge. When count==WRAP, count<=0.
//   - If lap_cnt==laps_l-1 (final wrap): cnt_en<=0, stop<=1, state DRAIN1.
//   - Otherwise lap_cnt++.
//  DRAIN1 -> DRAIN2 -> IDLE:
//   - on leaving DRAIN2: gnt<=0, done[idx]<=1, rr_ptr<=idx+1 (mod NREQ);
//   - done is high in the first IDLE cycle;
//   - a new grant/start can follow in the next cycle.
//  gnt stays stable from the start cycle through DRAIN2 inclusive.
//  Latency, L laps, req seen in cycle 0: start@1, count 0..WRAP over cycles 2..15 per lap (WRAP=13).
//   stop @ 2+14L, done @ 4+14L.
//  laps and req of non-granted requesters are ignored during a run. Changes to laps after the grant are ignored.
//  The count arithmetic is modulo WRAP+1 and never reaches values above WRAP.
//  start and stop are never high in the same cycle.
// CONFIGURATION
//  CTR_SCHED_ABORT_EN defined:
//   - in RUN, if req[idx] drops: next edge cnt_en<=0, count<=0, stop<=1, state DRAIN1;
//   - done still pulses after the drain;
//   - a final-wrap edge coinciding with req drop counts as a normal completion.
//  CTR_SCHED_ABORT_EN undefined: req drop is ignored; the run completes all laps.
// STRUCTURE
//  Package ctr_sched_pkg: state enum (IDLE, RUN, DRAIN1, DRAIN2) and the DRAIN_CYC=2 constant.
//  Sub-module run_ctr: SR enable flop plus modulo-(WRAP+1) counter.
//   - inputs: start, stop; output: wrap strobe;
//   - instantiated once;
//   - the scheduler holds the FSM, round-robin arbiter and lap counter.
// TESTING
//  1. Single run: req[0]=1, laps[0]=1 -> start@1, count 0..13, stop@16, done[0]@18, gnt[0] high cycles 1..17.
//  2. laps[2]=0 -> treated as 1 lap; laps[1]=3 -> stop exactly 42 enabled cycles after start.
//  3. Round-robin fairness, req=4'b1111 held, laps=1:
//   - grants go 0,1,2,3,0 in order;
//   - back-to-back: next start the cycle after done.
//  4. Reset asserted in RUN at count=7 -> next cycle all outputs 0, no done.
//     After reset release with req held: fresh grant from rr_ptr=0.
//  5. ABORT_EN: drop req[1] at count=5 of lap 1 -> stop the next cycle, done[1] 2 cycles later.
//     Without the macro: the full run completes.
//  6. Simultaneous events: req[3] rises in the done cycle of requester 2.
//     Check: grant 3 starts next cycle; there is never more than one gnt bit set.

Source files
------------

// File: rtl/ctr_sched_pkg.sv
// Shared types and constants for the run scheduler.
//   state_e   : scheduler FSM states
//   DRAIN_CYC : cycles between stop and done
package ctr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN1 = 2'd2,
    DRAIN2 = 2'd3
  } state_e;

  localparam int unsigned DRAIN_CYC = 2;

endpackage

// File: rtl/run_ctr.sv
// Modulo-(WRAP+1) interval counter with a set/reset enable flop.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_start     : set enable, clear count
//   i_stop      : clear enable and count (wins over i_start)
//   o_count     : current count (0..WRAP)
//   o_cnt_en    : enable flop state
//   o_wrap_c    : combinational strobe, enabled and count at WRAP this cycle
module run_ctr #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned WRAP  = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  output logic [CNT_W-1:0] o_count,
  output logic             o_cnt_en,
  output logic             o_wrap_c
);

  logic [CNT_W-1:0] r_count;
  logic             r_cnt_en;
  logic             w_at_wrap;

  assign w_at_wrap = (r_count == CNT_W'(WRAP));

  // Enable flop and counter; stop also returns the count to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_cnt_en <= 1'b0;
    end else if (i_stop) begin
      r_count  <= '0;
      r_cnt_en <= 1'b0;
    end else if (i_start) begin
      r_count  <= '0;
      r_cnt_en <= 1'b1;
    end else if (r_cnt_en) begin
      r_count  <= w_at_wrap ? '0 : r_count + CNT_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_cnt_en = r_cnt_en;
  assign o_wrap_c = r_cnt_en && w_at_wrap;

endmodule

// File: rtl/ctr_run_scheduler.sv
// Round-robin scheduler sharing one interval counter between NREQ requesters.
// Each grant runs the counter for the requested number of laps, then drains
// two cycles before signalling done.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req        : level request per requester
//   laps       : per-requester lap count, slice i = laps[i*LAP_W +: LAP_W], 0 means 1
//   gnt        : one-hot grant
//   busy       : any grant active
//   start/stop : one-cycle run begin / end pulses
//   count      : counter value
//   cnt_en     : counter enable
//   done       : one-cycle completion pulse to the finished requester
// Build option: CTR_SCHED_ABORT_EN -- dropping the granted req in RUN aborts the run.
module ctr_run_scheduler
  import ctr_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned WRAP  = 13,
  parameter int unsigned LAP_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LAP_W-1:0] laps,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  start,
  output logic                  stop,
  output logic [CNT_W-1:0]      count,
  output logic                  cnt_en,
  output logic [NREQ-1:0]       done
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt, r_done, w_done_nxt;
  logic              r_busy, r_start, w_start_nxt, r_stop, w_stop_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt, r_rr_ptr, w_rr_nxt, w_pick, w_cand;
  logic [LAP_W-1:0]  r_laps, w_laps_nxt, r_lap_cnt, w_lap_cnt_nxt, w_pick_laps;
  logic              w_any, w_stop_cmd, w_wrap;

  run_ctr #(.CNT_W(CNT_W), .WRAP(WRAP)) u_run_ctr (
    .clk      (clk),
    .reset    (reset),
    .i_start  (r_start),
    .i_stop   (w_stop_cmd),
    .o_count  (count),
    .o_cnt_en (cnt_en),
    .o_wrap_c (w_wrap)
  );

  // Round-robin pick: first set req scanning upward from r_rr_ptr.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_cand = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = IDX_W'((32'(r_rr_ptr) + k) % NREQ);
      if (!w_any && req[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  assign w_pick_laps = laps[32'(w_pick)*LAP_W +: LAP_W];

  // Next-state and registered-output values.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_start_nxt   = 1'b0;
    w_stop_nxt    = 1'b0;
    w_done_nxt    = '0;
    w_idx_nxt     = r_idx;
    w_laps_nxt    = r_laps;
    w_lap_cnt_nxt = r_lap_cnt;
    w_rr_nxt      = r_rr_ptr;
    w_stop_cmd    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_idx_nxt   = w_pick;
          w_laps_nxt  = (w_pick_laps == '0) ? LAP_W'(1) : w_pick_laps;
          w_gnt_nxt   = NREQ'(1) << w_pick;
          w_start_nxt = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_start) begin
          w_lap_cnt_nxt = '0;
        end else if (w_wrap) begin
          // Final wrap ends the run; the counter clears on the same edge.
          if (r_lap_cnt == r_laps - LAP_W'(1)) begin
            w_stop_cmd  = 1'b1;
            w_stop_nxt  = 1'b1;
            w_state_nxt = DRAIN1;
          end else begin
            w_lap_cnt_nxt = r_lap_cnt + LAP_W'(1);
          end
        end
`ifdef CTR_SCHED_ABORT_EN
        if (!req[r_idx]) begin
          w_stop_cmd  = 1'b1;
          w_stop_nxt  = 1'b1;
          w_state_nxt = DRAIN1;
        end
`endif
      end
      DRAIN1: begin
        w_state_nxt = DRAIN2;
      end
      DRAIN2: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_done_nxt  = NREQ'(1) << r_idx;
        w_rr_nxt    = (r_idx == IDX_W'(NREQ - 1)) ? '0 : r_idx + IDX_W'(1);
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_done    <= '0;
      r_idx     <= '0;
      r_laps    <= '0;
      r_lap_cnt <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_busy    <= |w_gnt_nxt;
      r_start   <= w_start_nxt;
      r_stop    <= w_stop_nxt;
      r_done    <= w_done_nxt;
      r_idx     <= w_idx_nxt;
      r_laps    <= w_laps_nxt;
      r_lap_cnt <= w_lap_cnt_nxt;
      r_rr_ptr  <= w_rr_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign busy  = r_busy;
  assign start = r_start;
  assign stop  = r_stop;
  assign done  = r_done;

endmodule

// File: tb/tb_ctr_run_scheduler.sv
// Self-checking bench for ctr_run_scheduler: directed scenarios with literal
// timing expectations, then randomized traffic against a run-timeline model.
module tb_ctr_run_scheduler;
  import ctr_sched_pkg::*;

  localparam int NREQ    = 4;
  localparam int CNT_W   = 4;
  localparam int WRAP    = 13;
  localparam int LAP_W   = 4;
  localparam int LAP_LEN = WRAP + 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*LAP_W-1:0] laps;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  start;
  logic                  stop;
  logic [CNT_W-1:0]      count;
  logic                  cnt_en;
  logic [NREQ-1:0]       done;

  always #5 clk = ~clk;

  ctr_run_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W), .WRAP(WRAP), .LAP_W(LAP_W)) dut (
    .clk(clk), .reset(reset), .req(req), .laps(laps), .gnt(gnt), .busy(busy),
    .start(start), .stop(stop), .count(count), .cnt_en(cnt_en), .done(done)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: one run described by the cycle its request was seen and its stop offset.
  bit m_active = 1'b0;
  int m_t0, m_idx, m_stop_off;
  int m_rr = 0;
  logic [NREQ-1:0] exp_done;
  logic [NREQ-1:0] persist;

  // Event log of observed DUT behaviour for literal timing checks.
  int ev_start[64], ev_start_idx[64], ev_stop[64], ev_done[64];
  int n_start, n_stop, n_done, en_cnt, gnt0_cnt;
  logic [CNT_W-1:0] last_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 64; i++) begin
      ev_start[i] = -1000; ev_start_idx[i] = -1; ev_stop[i] = -1000; ev_done[i] = -1000;
    end
    n_start = 0; n_stop = 0; n_done = 0; en_cnt = 0; gnt0_cnt = 0;
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] g);
    int r = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (g[i] === 1'b1) r = i;
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r);
    int p = -1;
    for (int k = NREQ - 1; k >= 0; k--) if (r[(m_rr + k) % NREQ]) p = (m_rr + k) % NREQ;
    return p;
  endfunction

  // Compare all outputs of the current cycle against the model.
  task automatic tick();
    logic [NREQ-1:0]  e_gnt;
    logic             e_start, e_stop, e_en;
    logic [CNT_W-1:0] e_cnt;
    int d;
    @(negedge clk);
    cyc++;
    e_gnt = '0; e_start = 1'b0; e_stop = 1'b0; e_en = 1'b0; e_cnt = '0; exp_done = '0;
    if (m_active) begin
      d = cyc - m_t0;
      if (d == 1) e_start = 1'b1;
      if (d >= 1 && d <= m_stop_off + 1) e_gnt = NREQ'(1) << m_idx;
      if (d >= 2 && d < m_stop_off) begin
        e_en  = 1'b1;
        e_cnt = CNT_W'((d - 2) % LAP_LEN);
      end
      if (d == m_stop_off) e_stop = 1'b1;
      if (d == m_stop_off + 2) exp_done = NREQ'(1) << m_idx;
    end
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("busy", 32'(busy), 32'(e_gnt != '0));
    chk("start", 32'(start), 32'(e_start));
    chk("stop", 32'(stop), 32'(e_stop));
    chk("cnt_en", 32'(cnt_en), 32'(e_en));
    chk("count", 32'(count), 32'(e_cnt));
    chk("done", 32'(done), 32'(exp_done));
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    if (start === 1'b1 && n_start < 64) begin
      ev_start[n_start] = cyc; ev_start_idx[n_start] = idx_of(gnt); n_start++;
    end
    if (stop === 1'b1 && n_stop < 64) begin ev_stop[n_stop] = cyc; n_stop++; end
    if (done != '0 && n_done < 64) begin ev_done[n_done] = cyc; n_done++; end
    if (cnt_en === 1'b1) en_cnt++;
    if (gnt[0] === 1'b1) gnt0_cnt++;
    last_count = count;
  endtask

  // Advance the model with the inputs sampled at the end of this cycle.
  task automatic model_update();
    int d;
    logic [LAP_W-1:0] lv;
    if (reset) begin
      m_active = 1'b0;
      m_rr = 0;
      return;
    end
    if (m_active) begin
      d = cyc - m_t0;
`ifdef CTR_SCHED_ABORT_EN
      if (d >= 1 && d < m_stop_off && !req[m_idx]) m_stop_off = d + 1;
`endif
      if (d == m_stop_off + 2) begin
        m_active = 1'b0;
        m_rr = (m_idx + 1) % NREQ;
      end
    end
    if (!m_active && req != '0) begin
      m_idx = pick(req);
      lv = laps[m_idx*LAP_W +: LAP_W];
      m_t0 = cyc;
      m_stop_off = 2 + LAP_LEN * ((lv == '0) ? 1 : int'(lv));
      m_active = 1'b1;
    end
  endtask

  // One cycle: check, then drive inputs (requesters release on done unless persistent).
  task automatic step(input logic [NREQ-1:0] raise, input logic [NREQ-1:0] drop,
                      input logic rst, input logic [NREQ*LAP_W-1:0] lv);
    tick();
    req   = ((req & ~(exp_done & ~persist)) & ~drop) | raise;
    reset = rst;
    laps  = lv;
    model_update();
  endtask

  task automatic drain();
    for (int k = 0; k < 800 && (req != '0 || m_active); k++) step('0, '0, 1'b0, laps);
    chk("drain_idle", 32'(req != '0 || m_active), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tdrop, tdone;
    logic [NREQ-1:0] rs, dr;
    logic [NREQ*LAP_W-1:0] lv;
    reset = 1'b1; req = '0; laps = '0; persist = '0;
    clear_log();
    step('0, '0, 1'b1, '0);
    step('0, '0, 1'b1, '0);

    // Single one-lap run for requester 0.
    clear_log();
    step(4'b0001, '0, 1'b0, 16'h0001);
    t0 = cyc;
    repeat (25) step('0, '0, 1'b0, 16'h0001);
    chk("t1_start", 32'(ev_start[0] - t0), 32'd1);
    chk("t1_stop", 32'(ev_stop[0] - t0), 32'd16);
    chk("t1_done", 32'(ev_done[0] - t0), 32'd18);
    chk("t1_gnt_cycles", 32'(gnt0_cnt), 32'd17);

    // laps[1]=3 then laps[2]=0 (one lap).
    clear_log();
    step(4'b0110, '0, 1'b0, 16'h0030);
    repeat (70) step('0, '0, 1'b0, 16'h0030);
    chk("t2_first_idx", 32'(ev_start_idx[0]), 32'd1);
    chk("t2_3lap_len", 32'(ev_stop[0] - ev_start[0]), 32'd43);
    chk("t2_drain", 32'(ev_done[0] - ev_stop[0]), 32'(DRAIN_CYC));
    chk("t2_second_idx", 32'(ev_start_idx[1]), 32'd2);
    chk("t2_zero_lap_len", 32'(ev_stop[1] - ev_start[1]), 32'd15);
    chk("t2_enabled_cycles", 32'(en_cnt), 32'd56);

    // Round-robin with all requests held.
    step('0, '0, 1'b1, '0);
    clear_log();
    persist = '1;
    step(4'b1111, '0, 1'b0, 16'h1111);
    repeat (91) step('0, '0, 1'b0, 16'h1111);
    persist = '0;
    drain();
    for (int k = 0; k < 5; k++) chk("t3_order", 32'(ev_start_idx[k]), 32'(k % NREQ));
    for (int k = 0; k < 4; k++) chk("t3_back_to_back", 32'(ev_start[k+1] - ev_done[k]), 32'd1);

    // Reset mid-run clears everything and restarts round-robin from 0.
    step('0, '0, 1'b1, '0);
    step(4'b0100, '0, 1'b0, 16'h1111);
    drain();
    clear_log();
    step(4'b1000, '0, 1'b0, 16'h1111);
    for (int k = 0; k < 40 && !(m_active && cyc - m_t0 == 8); k++) step('0, '0, 1'b0, 16'h1111);
    step('0, '0, 1'b1, 16'h1111);
    chk("t4_count_at_reset", 32'(last_count), 32'd7);
    step(4'b0001, '0, 1'b0, 16'h1111);
    repeat (3) step('0, '0, 1'b0, 16'h1111);
    chk("t4_no_done", 32'(n_done), 32'd0);
    chk("t4_fresh_grant", 32'(ev_start_idx[1]), 32'd0);
    drain();

    // Drop req[1] at count 5 of the first lap of a two-lap run.
    clear_log();
    step(4'b0010, '0, 1'b0, 16'h0020);
    t0 = cyc;
    for (int k = 0; k < 20 && cyc - t0 < 6; k++) step('0, '0, 1'b0, 16'h0020);
    step('0, 4'b0010, 1'b0, 16'h0020);
    tdrop = cyc;
    repeat (40) step('0, '0, 1'b0, 16'h0020);
`ifdef CTR_SCHED_ABORT_EN
    chk("t5_abort_stop", 32'(ev_stop[0] - tdrop), 32'd1);
    chk("t5_abort_done", 32'(ev_done[0] - tdrop), 32'd3);
`else
    chk("t5_full_stop", 32'(ev_stop[0] - t0), 32'd30);
    chk("t5_full_done", 32'(ev_done[0] - t0), 32'd32);
`endif
    drain();

    // req[3] rises in the done cycle of requester 2.
    clear_log();
    step(4'b0100, '0, 1'b0, 16'h1111);
    for (int k = 0; k < 60 && !(m_active && cyc + 1 - m_t0 == m_stop_off + 2); k++)
      step('0, '0, 1'b0, 16'h1111);
    step(4'b1000, '0, 1'b0, 16'h1111);
    tdone = cyc;
    repeat (3) step('0, '0, 1'b0, 16'h1111);
    chk("t6_done_cycle", 32'(ev_done[0]), 32'(tdone));
    chk("t6_next_idx", 32'(ev_start_idx[1]), 32'd3);
    chk("t6_next_start", 32'(ev_start[1] - tdone), 32'd1);
    drain();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rs = '0; dr = '0; lv = laps;
      for (int i = 0; i < NREQ; i++) begin
        if (m_active && m_idx == i) begin
          lv[i*LAP_W +: LAP_W] = LAP_W'($urandom);
`ifdef CTR_SCHED_ABORT_EN
          if ($urandom % 48 == 0) dr[i] = 1'b1;
`endif
        end else if (!req[i] && $urandom % 6 == 0) begin
          rs[i] = 1'b1;
          lv[i*LAP_W +: LAP_W] = ($urandom % 8 == 0) ? LAP_W'($urandom) : LAP_W'($urandom % 3);
        end
      end
      step(rs, dr, ($urandom % 500 == 0), lv);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
